// File: rtl/arp_pkg.sv
// Shared ARP frame layout, constants, result codes and the validate/build helpers.
// Used by the responder RTL and by anything that needs to reason about ARP frames.
package arp_pkg;

   localparam int lp_PROTO_FRM_SZ = 42;
   localparam int lp_MIN_FRM_SZ   = 60;

   localparam logic [47:0] lp_BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;
   localparam logic [15:0] lp_ETHERTYPE_ARP = 16'h0806;
   localparam logic [15:0] lp_HW_TYPE_ETH   = 16'h0001;
   localparam logic [15:0] lp_PROTO_IPV4    = 16'h0800;
   localparam logic [7:0]  lp_HW_LEN        = 8'd6;
   localparam logic [7:0]  lp_PROTO_LEN     = 8'd4;
   localparam logic [15:0] lp_OP_REQUEST    = 16'h0001;
   localparam logic [15:0] lp_OP_REPLY      = 16'h0002;

   // Field order matches wire order, so byte 0 lands in the MSBs.
   typedef struct packed {
      logic [47:0] dst_mac;
      logic [47:0] src_mac;
      logic [15:0] ethertype;
      logic [15:0] hw_type;
      logic [15:0] proto_type;
      logic [7:0]  hw_len;
      logic [7:0]  proto_len;
      logic [15:0] opcode;
      logic [47:0] sender_mac;
      logic [31:0] sender_ip;
      logic [47:0] target_mac;
      logic [31:0] target_ip;
   } proto_frame_t;

   typedef enum logic [3:0] {
      RES_OK         = 4'd0,
      RES_DST_MAC    = 4'd1,
      RES_SRC_MAC    = 4'd2,
      RES_ETHERTYPE  = 4'd3,
      RES_HW_TYPE    = 4'd4,
      RES_PROTO_TYPE = 4'd5,
      RES_HW_LEN     = 4'd6,
      RES_PROTO_LEN  = 4'd7,
      RES_OPCODE     = 4'd8,
      RES_TARGET_IP  = 4'd9,
      RES_RUNT       = 4'd10,
      RES_DROP       = 4'd11
   } arp_result_e;

   typedef enum logic [1:0] {RX_HDR, RX_SKIP, RX_CHK} rx_state_e;
   typedef enum logic [1:0] {TX_IDLE, TX_USR, TX_ARP} tx_state_e;

   function automatic arp_result_e validate_proto_frame(input proto_frame_t f,
                                                        input logic [47:0] mac,
                                                        input logic [31:0] ip);
      arp_result_e r;
      if (f.dst_mac != mac && f.dst_mac != lp_BROADCAST_MAC) r = RES_DST_MAC;
      else if (f.src_mac == mac)                            r = RES_SRC_MAC;
      else if (f.ethertype != lp_ETHERTYPE_ARP)             r = RES_ETHERTYPE;
      else if (f.hw_type != lp_HW_TYPE_ETH)                 r = RES_HW_TYPE;
      else if (f.proto_type != lp_PROTO_IPV4)               r = RES_PROTO_TYPE;
      else if (f.hw_len != lp_HW_LEN)                       r = RES_HW_LEN;
      else if (f.proto_len != lp_PROTO_LEN)                 r = RES_PROTO_LEN;
      else if (f.opcode != lp_OP_REQUEST)                   r = RES_OPCODE;
      else if (f.target_ip != ip)                           r = RES_TARGET_IP;
      else                                                  r = RES_OK;
      return r;
   endfunction

   function automatic proto_frame_t build_reply_pkt(input proto_frame_t req,
                                                    input logic [47:0] mac,
                                                    input logic [31:0] ip);
      proto_frame_t r;
      r.dst_mac    = req.src_mac;
      r.src_mac    = mac;
      r.ethertype  = lp_ETHERTYPE_ARP;
      r.hw_type    = lp_HW_TYPE_ETH;
      r.proto_type = lp_PROTO_IPV4;
      r.hw_len     = lp_HW_LEN;
      r.proto_len  = lp_PROTO_LEN;
      r.opcode     = lp_OP_REPLY;
      r.sender_mac = mac;
      r.sender_ip  = ip;
      r.target_mac = req.sender_mac;
      r.target_ip  = req.sender_ip;
      return r;
   endfunction

endpackage

// File: rtl/arp_tx_arb.sv
// Frame-level arbiter between the pending ARP reply and the user stream, with reply serializer.
// Combinational mux to TX; data/last held until tx_ready_i; one idle bubble after every frame.
module arp_tx_arb
   import arp_pkg::*;
#(
   parameter bit P_PAD_EN = 1'b1
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  proto_frame_t reply_i,
   input  logic         pending_i,
   input  logic [7:0]   usr_data_i,
   input  logic         usr_valid_i,
   input  logic         usr_last_i,
   output logic         usr_ready_o,
   output logic [7:0]   tx_data_o,
   output logic         tx_valid_o,
   output logic         tx_last_o,
   input  logic         tx_ready_i,
   output logic         pend_clr_o,
   output logic         idle_o
);

   localparam logic [5:0] lp_LAST_IDX = P_PAD_EN ? 6'(lp_MIN_FRM_SZ - 1)
                                                 : 6'(lp_PROTO_FRM_SZ - 1);
   localparam int lp_BITS = lp_PROTO_FRM_SZ * 8;

   tx_state_e            state_q, state_d;
   logic [5:0]           cnt_q, cnt_d;
   logic [lp_BITS-1:0]   shifted;

   // Shifting past the 42 header bytes yields zeros, which doubles as the pad.
   assign shifted = reply_i << {cnt_q, 3'b000};
   assign idle_o  = (state_q == TX_IDLE);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= TX_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      tx_data_o   = 8'h00;
      tx_valid_o  = 1'b0;
      tx_last_o   = 1'b0;
      usr_ready_o = 1'b0;
      pend_clr_o  = 1'b0;
      case (state_q)
         TX_IDLE: begin
            if (pending_i) begin
               state_d = TX_ARP;
               cnt_d   = '0;
            end else if (usr_valid_i) begin
               state_d = TX_USR;
            end
         end
         TX_USR: begin
            tx_data_o   = usr_data_i;
            tx_valid_o  = usr_valid_i;
            tx_last_o   = usr_last_i;
            usr_ready_o = tx_ready_i;
            if (usr_valid_i && tx_ready_i && usr_last_i) state_d = TX_IDLE;
         end
         TX_ARP: begin
            tx_data_o  = shifted[lp_BITS-1 -: 8];
            tx_valid_o = 1'b1;
            tx_last_o  = (cnt_q == lp_LAST_IDX);
            if (tx_ready_i) begin
               if (cnt_q == lp_LAST_IDX) begin
                  pend_clr_o = 1'b1;
                  cnt_d      = '0;
                  state_d    = TX_IDLE;
               end else begin
                  cnt_d = cnt_q + 6'd1;
               end
            end
         end
         default: state_d = TX_IDLE;
      endcase
   end

endmodule

// File: rtl/arp_responder_ctrl.sv
// ARP responder: captures RX headers, validates requests, buffers one reply, shares MAC TX.
// RX never stalls; reply starts two cycles after the check; TX obeys tx_ready_i per byte.
module arp_responder_ctrl
   import arp_pkg::*;
#(
   parameter int P_CNT_W  = 16,
   parameter bit P_PAD_EN = 1'b1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [47:0]        mac_addr_i,
   input  logic [31:0]        ip_addr_i,
   input  logic [7:0]         rx_data_i,
   input  logic               rx_valid_i,
   input  logic               rx_last_i,
   input  logic [7:0]         usr_data_i,
   input  logic               usr_valid_i,
   input  logic               usr_last_i,
   output logic               usr_ready_o,
   output logic [7:0]         tx_data_o,
   output logic               tx_valid_o,
   output logic               tx_last_o,
   input  logic               tx_ready_i,
   output logic [P_CNT_W-1:0] req_cnt_o,
   output logic [P_CNT_W-1:0] drop_cnt_o,
   output logic [3:0]         last_err_o,
   output logic               busy_o
);

   localparam int lp_BITS = lp_PROTO_FRM_SZ * 8;

   rx_state_e          rx_state_q, rx_state_d;
   logic [5:0]         idx_q, idx_d;
   logic [lp_BITS-1:0] cap_q, cap_d;
   proto_frame_t       reply_q, reply_d;
   logic               pending_q, pending_d;
   logic [P_CNT_W-1:0] req_cnt_q, req_cnt_d;
   logic [P_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   arp_result_e        err_q, err_d;
   arp_result_e        chk_res;
   logic               pend_set;
   logic               pend_clr;
   logic               tx_idle;

   assign chk_res    = validate_proto_frame(proto_frame_t'(cap_q), mac_addr_i, ip_addr_i);
   assign req_cnt_o  = req_cnt_q;
   assign drop_cnt_o = drop_cnt_q;
   assign last_err_o = err_q;
   assign busy_o     = pending_q | ~tx_idle;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_state_q <= RX_HDR;
         idx_q      <= '0;
         cap_q      <= '0;
         reply_q    <= '0;
         pending_q  <= 1'b0;
         req_cnt_q  <= '0;
         drop_cnt_q <= '0;
         err_q      <= RES_OK;
      end else begin
         rx_state_q <= rx_state_d;
         idx_q      <= idx_d;
         cap_q      <= cap_d;
         reply_q    <= reply_d;
         pending_q  <= pending_d;
         req_cnt_q  <= req_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      rx_state_d = rx_state_q;
      idx_d      = idx_q;
      cap_d      = cap_q;
      reply_d    = reply_q;
      req_cnt_d  = req_cnt_q;
      drop_cnt_d = drop_cnt_q;
      err_d      = err_q;
      pend_set   = 1'b0;
      case (rx_state_q)
         RX_HDR: begin
            if (rx_valid_i) begin
               cap_d = {cap_q[lp_BITS-9:0], rx_data_i};
               if (idx_q == 6'(lp_PROTO_FRM_SZ - 1)) begin
                  idx_d      = '0;
                  rx_state_d = rx_last_i ? RX_CHK : RX_SKIP;
               end else if (rx_last_i) begin
                  idx_d = '0;
                  err_d = RES_RUNT;
               end else begin
                  idx_d = idx_q + 6'd1;
               end
            end
         end
         RX_SKIP: begin
            if (rx_valid_i && rx_last_i) rx_state_d = RX_CHK;
         end
         RX_CHK: begin
            rx_state_d = RX_HDR;
            if (chk_res != RES_OK) begin
               err_d = chk_res;
            end else if (!pending_q) begin
               reply_d  = build_reply_pkt(proto_frame_t'(cap_q), mac_addr_i, ip_addr_i);
               pend_set = 1'b1;
               err_d    = RES_OK;
               if (~&req_cnt_q) req_cnt_d = req_cnt_q + P_CNT_W'(1);
            end else begin
               err_d = RES_DROP;
               if (~&drop_cnt_q) drop_cnt_d = drop_cnt_q + P_CNT_W'(1);
            end
            // A byte here is byte 0 of the next frame; a 1-byte frame is a runt.
            if (rx_valid_i) begin
               cap_d = {cap_q[lp_BITS-9:0], rx_data_i};
               if (rx_last_i) err_d = RES_RUNT;
               else           idx_d = 6'd1;
            end
         end
         default: rx_state_d = RX_HDR;
      endcase
   end

   // A pass is only loaded when pending_q is low, so set and clear never collide.
   assign pending_d = (pending_q & ~pend_clr) | pend_set;

   arp_tx_arb #(
      .P_PAD_EN (P_PAD_EN)
   ) u_tx_arb (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .reply_i     (reply_q),
      .pending_i   (pending_q),
      .usr_data_i  (usr_data_i),
      .usr_valid_i (usr_valid_i),
      .usr_last_i  (usr_last_i),
      .usr_ready_o (usr_ready_o),
      .tx_data_o   (tx_data_o),
      .tx_valid_o  (tx_valid_o),
      .tx_last_o   (tx_last_o),
      .tx_ready_i  (tx_ready_i),
      .pend_clr_o  (pend_clr),
      .idle_o      (tx_idle)
   );

endmodule

// File: tb/tb_arp_responder_ctrl.sv
// Directed bench for arp_responder_ctrl: vector table of RX frames plus hand-written
// sequences for user/ARP interleave, reply-buffer drop and mid-reply reset.
module tb_arp_responder_ctrl;

   localparam logic [47:0] LMAC = 48'h02_00_00_00_00_02;
   localparam logic [31:0] LIP  = 32'h0A_00_00_02;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rx_data_i = '0;
   logic        rx_valid_i = 1'b0;
   logic        rx_last_i = 1'b0;
   logic [7:0]  usr_data_i = '0;
   logic        usr_valid_i = 1'b0;
   logic        usr_last_i = 1'b0;
   logic        usr_ready_o;
   logic [7:0]  tx_data_o;
   logic        tx_valid_o;
   logic        tx_last_o;
   logic        tx_ready_i = 1'b1;
   logic [15:0] req_cnt_o;
   logic [15:0] drop_cnt_o;
   logic [3:0]  last_err_o;
   logic        busy_o;

   always #5 clk = ~clk;

   arp_responder_ctrl #(.P_CNT_W(16), .P_PAD_EN(1'b1)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .mac_addr_i  (LMAC),
      .ip_addr_i   (LIP),
      .rx_data_i   (rx_data_i),
      .rx_valid_i  (rx_valid_i),
      .rx_last_i   (rx_last_i),
      .usr_data_i  (usr_data_i),
      .usr_valid_i (usr_valid_i),
      .usr_last_i  (usr_last_i),
      .usr_ready_o (usr_ready_o),
      .tx_data_o   (tx_data_o),
      .tx_valid_o  (tx_valid_o),
      .tx_last_o   (tx_last_o),
      .tx_ready_i  (tx_ready_i),
      .req_cnt_o   (req_cnt_o),
      .drop_cnt_o  (drop_cnt_o),
      .last_err_o  (last_err_o),
      .busy_o      (busy_o)
   );

   typedef struct {
      logic [47:0] dst;
      logic [47:0] src;
      logic [15:0] etype;
      logic [15:0] htype;
      logic [15:0] ptype;
      logic [7:0]  hlen;
      logic [7:0]  plen;
      logic [15:0] op;
      logic [47:0] smac;
      logic [31:0] sip;
      logic [47:0] tmac;
      logic [31:0] tip;
      int          len;
      logic [3:0]  exp_err;
      bit          exp_reply;
   } vec_t;

   typedef struct {
      logic [7:0] d;
      logic       l;
      logic       ur;
      int         cyc;
   } txrec_t;

   txrec_t txq[$];
   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int exp_req = 0;
   int exp_drop = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk)
      if (rst_n && tx_valid_o && tx_ready_i)
         txq.push_back('{tx_data_o, tx_last_o, usr_ready_o, cyc});

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [511:0] frame_bits(input vec_t v);
      return {v.dst, v.src, v.etype, v.htype, v.ptype, v.hlen, v.plen, v.op,
              v.smac, v.sip, v.tmac, v.tip, {22{8'h55}}};
   endfunction

   // Expected 60-byte reply written out field by field.
   function automatic logic [479:0] reply_bits(input vec_t v);
      return {v.src, LMAC, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0002,
              LMAC, LIP, v.smac, v.sip, 144'h0};
   endfunction

   task automatic send_frame(input vec_t v);
      logic [511:0] fb;
      fb = frame_bits(v);
      for (int i = 0; i < v.len; i++) begin
         rx_valid_i = 1'b1;
         rx_data_i  = fb[511-8*i -: 8];
         rx_last_i  = (i == v.len - 1);
         @(posedge clk); #1;
      end
      rx_valid_i = 1'b0;
      rx_last_i  = 1'b0;
   endtask

   task automatic usr_send(input int len, input logic [7:0] base);
      int w;
      for (int i = 0; i < len; i++) begin
         usr_valid_i = 1'b1;
         usr_data_i  = base + 8'(i);
         usr_last_i  = (i == len - 1);
         w = 0;
         @(negedge clk);
         while (!usr_ready_o && w < 500) begin
            w++;
            @(negedge clk);
         end
         chk("usr handshake timeout", (w < 500), 1);
         @(posedge clk); #1;
      end
      usr_valid_i = 1'b0;
      usr_last_i  = 1'b0;
   endtask

   task automatic check_reply(input string name, input vec_t v, input int base);
      logic [479:0] eb;
      int bad;
      eb  = reply_bits(v);
      bad = 0;
      for (int i = 0; i < 60; i++) begin
         if (base + i >= txq.size()) bad++;
         else if (txq[base+i].d !== eb[479-8*i -: 8] || txq[base+i].l !== (i == 59)) bad++;
      end
      chk({name, " bad reply bytes"}, bad, 0);
   endtask

   initial begin
      vec_t tv[14];
      vec_t b;
      int   bad;
      int   w;

      tx_ready_i = 1'b1;
      #12;
      chk("rst tx_valid", tx_valid_o, 0);
      chk("rst tx_last", tx_last_o, 0);
      chk("rst tx_data", tx_data_o, 0);
      chk("rst usr_ready", usr_ready_o, 0);
      chk("rst req_cnt", req_cnt_o, 0);
      chk("rst drop_cnt", drop_cnt_o, 0);
      chk("rst last_err", last_err_o, 0);
      chk("rst busy", busy_o, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      b.dst = 48'hFFFF_FFFF_FFFF;  b.src = 48'h02_00_00_00_00_01;
      b.etype = 16'h0806; b.htype = 16'h0001; b.ptype = 16'h0800;
      b.hlen = 8'd6; b.plen = 8'd4; b.op = 16'h0001;
      b.smac = 48'h02_00_00_00_00_01; b.sip = 32'h0A00_0001;
      b.tmac = 48'h0; b.tip = LIP;
      b.len = 42; b.exp_err = 4'd0; b.exp_reply = 1'b1;

      tv[0] = b;
      tv[1] = b;  tv[1].tip = 32'h0A00_0003;          tv[1].exp_err = 4'd9;  tv[1].exp_reply = 1'b0;
      tv[2] = b;  tv[2].dst = 48'h02_00_00_00_00_99;  tv[2].exp_err = 4'd1;  tv[2].exp_reply = 1'b0;
      tv[3] = b;  tv[3].dst = LMAC;
      tv[4] = b;  tv[4].src = LMAC;                   tv[4].exp_err = 4'd2;  tv[4].exp_reply = 1'b0;
      tv[5] = b;  tv[5].etype = 16'h0800;             tv[5].exp_err = 4'd3;  tv[5].exp_reply = 1'b0;
      tv[6] = b;  tv[6].htype = 16'h0002;             tv[6].exp_err = 4'd4;  tv[6].exp_reply = 1'b0;
      tv[7] = b;  tv[7].ptype = 16'h86DD;             tv[7].exp_err = 4'd5;  tv[7].exp_reply = 1'b0;
      tv[8] = b;  tv[8].hlen = 8'd5;                  tv[8].exp_err = 4'd6;  tv[8].exp_reply = 1'b0;
      tv[9] = b;  tv[9].plen = 8'd6;                  tv[9].exp_err = 4'd7;  tv[9].exp_reply = 1'b0;
      tv[10] = b; tv[10].op = 16'h0002;               tv[10].exp_err = 4'd8; tv[10].exp_reply = 1'b0;
      tv[11] = b; tv[11].len = 30;                    tv[11].exp_err = 4'd10; tv[11].exp_reply = 1'b0;
      tv[12] = b; tv[12].len = 64; tv[12].src = 48'h02_00_00_00_00_05;
      tv[12].smac = 48'h02_00_00_00_00_05; tv[12].sip = 32'h0A00_0007;
      tv[13] = b; tv[13].etype = 16'h0800; tv[13].tip = 32'h0A00_0003;
      tv[13].exp_err = 4'd3; tv[13].exp_reply = 1'b0;

      for (int k = 0; k < 14; k++) begin
         txq.delete();
         send_frame(tv[k]);
         repeat (80) @(posedge clk);
         @(negedge clk);
         if (tv[k].exp_reply) exp_req++;
         chk($sformatf("v%0d last_err", k), last_err_o, tv[k].exp_err);
         chk($sformatf("v%0d req_cnt", k), req_cnt_o, exp_req);
         chk($sformatf("v%0d drop_cnt", k), drop_cnt_o, exp_drop);
         chk($sformatf("v%0d tx bytes", k), txq.size(), tv[k].exp_reply ? 60 : 0);
         if (tv[k].exp_reply) check_reply($sformatf("v%0d", k), tv[k], 0);
         chk($sformatf("v%0d busy", k), busy_o, 0);
         @(posedge clk); #1;
      end

      // User frame in flight while a request passes.
      txq.delete();
      fork
         send_frame(tv[0]);
         begin
            usr_send(100, 8'h00);
            usr_send(1, 8'hEE);
         end
      join
      repeat (10) @(posedge clk);
      @(negedge clk);
      exp_req++;
      chk("interleave tx bytes", txq.size(), 161);
      chk("interleave req_cnt", req_cnt_o, exp_req);
      if (txq.size() >= 161) begin
         bad = 0;
         for (int i = 0; i < 100; i++)
            if (txq[i].d !== 8'(i) || txq[i].l !== (i == 99) || txq[i].ur !== 1'b1) bad++;
         chk("interleave user bytes bad", bad, 0);
         check_reply("interleave arp", tv[0], 100);
         bad = 0;
         for (int i = 100; i < 160; i++) if (txq[i].ur !== 1'b0) bad++;
         chk("usr_ready during arp", bad, 0);
         chk("bubble usr->arp", txq[100].cyc - txq[99].cyc, 2);
         chk("bubble arp->usr", txq[160].cyc - txq[159].cyc, 2);
         chk("second user byte", {txq[160].d, 7'b0, txq[160].l}, 16'hEE01);
      end
      @(posedge clk); #1;

      // Reply buffer full: second pass is dropped while TX is stalled.
      txq.delete();
      tx_ready_i = 1'b0;
      send_frame(tv[0]);
      send_frame(tv[12]);
      repeat (4) @(posedge clk);
      @(negedge clk);
      exp_req++;
      exp_drop++;
      chk("drop drop_cnt", drop_cnt_o, exp_drop);
      chk("drop last_err", last_err_o, 11);
      chk("drop req_cnt", req_cnt_o, exp_req);
      chk("stall tx_valid", tx_valid_o, 1);
      chk("stall tx_data", tx_data_o, 8'h02);
      chk("stall tx_last", tx_last_o, 0);
      chk("stall busy", busy_o, 1);
      repeat (6) @(negedge clk);
      chk("stall tx_data held", tx_data_o, 8'h02);
      chk("stall tx_valid held", tx_valid_o, 1);
      @(posedge clk); #1 tx_ready_i = 1'b1;
      repeat (100) @(posedge clk);
      @(negedge clk);
      chk("drop tx bytes", txq.size(), 60);
      check_reply("drop", tv[0], 0);
      chk("drop busy", busy_o, 0);
      @(posedge clk); #1;

      // Reset in the middle of a reply.
      txq.delete();
      send_frame(tv[0]);
      w = 0;
      while (txq.size() < 20 && w < 200) begin
         @(negedge clk); #2;
         w++;
      end
      chk("reply start timeout", (w < 200), 1);
      chk("mid-reply tx_valid", tx_valid_o, 1);
      rst_n = 1'b0;
      #1;
      exp_req = 0;
      exp_drop = 0;
      chk("async rst tx_valid", tx_valid_o, 0);
      chk("async rst req_cnt", req_cnt_o, 0);
      chk("async rst drop_cnt", drop_cnt_o, 0);
      chk("async rst busy", busy_o, 0);
      chk("async rst last_err", last_err_o, 0);
      txq.delete();
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      send_frame(tv[0]);
      repeat (80) @(posedge clk);
      @(negedge clk);
      exp_req++;
      chk("post rst tx bytes", txq.size(), 60);
      check_reply("post rst", tv[0], 0);
      chk("post rst req_cnt", req_cnt_o, exp_req);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
